// File: rtl/spi_load_sequencer.sv
// Sequencer for a single SPI flash load: starts the loader, pops 32-bit words from the loader
// FIFO, and writes them to consecutive memory addresses. Handles abort and empty-FIFO timeout.
module spi_load_sequencer #(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [ADDR_W-1:0] i_base,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_init,
    output logic              o_fill,
    input  logic              i_fifo_empty,
    output logic              o_fifo_rd,
    input  logic [31:0]       i_fifo_dout,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ready
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StRd,
        StCap,
        StWr,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            rem_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tmo_d   = tmo_q;
        err_d   = err_q;

        case (state_q)
            StIdle: begin
                // Abort in IDLE only suppresses a coincident start.
                if (i_start && !i_abort) begin
                    err_d = 1'b0;
                    tmo_d = '0;
                    if (i_len != '0) begin
                        rem_d   = i_len;
                        addr_d  = i_base;
                        state_d = StInit;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StInit: state_d = StRd;
            StRd: begin
                if (!i_fifo_empty) begin
                    tmo_d   = '0;
                    state_d = StCap;
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StCap: begin
                wdata_d = i_fifo_dout;
                state_d = StWr;
            end
            StWr: begin
                if (i_mem_ready) begin
                    addr_d  = addr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == LEN_W'(1)) ? StDone : StRd;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (i_abort && (state_q != StIdle)) begin
            state_d = StIdle;
            tmo_d   = '0;
            err_d   = err_q;
        end
    end

    assign o_busy      = (state_q != StIdle);
    assign o_done      = (state_q == StDone);
    assign o_err       = err_q;
    assign o_init      = (state_q == StInit);
    assign o_fill      = (state_q == StInit) || (state_q == StRd) ||
                         (state_q == StCap) || (state_q == StWr);
    assign o_fifo_rd   = (state_q == StRd) && !i_fifo_empty;
    assign o_mem_we    = (state_q == StWr);
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_spi_load_sequencer.sv
// Scoreboard bench for spi_load_sequencer: FIFO model feeds words, expected writes are queued
// as words are pushed and popped as the DUT writes them.
module tb_spi_load_sequencer;

    localparam int unsigned ADDR_W      = 14;
    localparam int unsigned LEN_W       = 16;
    localparam int unsigned TIMEOUT_CYC = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_start, i_abort;
    logic [LEN_W-1:0]  i_len;
    logic [ADDR_W-1:0] i_base;
    logic              o_busy, o_done, o_err, o_init, o_fill;
    logic              fifo_empty, o_fifo_rd;
    logic [31:0]       fifo_dout = 32'h0;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic              i_mem_ready;

    logic [31:0] fifo_mem [256];
    int          push_cnt = 0;
    int          pop_cnt = 0;
    wr_t         exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    spi_load_sequencer #(
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_len       (i_len),
        .i_base      (i_base),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_init      (o_init),
        .o_fill      (o_fill),
        .i_fifo_empty(fifo_empty),
        .o_fifo_rd   (o_fifo_rd),
        .i_fifo_dout (fifo_dout),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ready (i_mem_ready)
    );

    assign fifo_empty = (push_cnt == pop_cnt);

    // Loader FIFO: data appears the cycle after a pop.
    always @(posedge clk) begin
        if (o_fifo_rd) begin
            fifo_dout <= fifo_mem[pop_cnt[7:0]];
            pop_cnt   <= pop_cnt + 1;
        end
    end

    task automatic push_word(input logic [31:0] d, input logic [ADDR_W-1:0] a, input bit exp_wr);
        fifo_mem[push_cnt[7:0]] = d;
        push_cnt++;
        if (exp_wr) exp_q.push_back({a, d});
    endtask

    // Returns at the negedge of cycle 1 (start sampled at edge 0).
    task automatic start_load(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] base);
        @(negedge clk);
        i_start = 1'b1;
        i_len   = len;
        i_base  = base;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({o_busy, o_done, o_err, o_init, o_fill, o_mem_we, o_fifo_rd} !== 7'b0 ||
            o_mem_addr !== '0 || o_mem_wdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_values: flags=%b addr=%h data=%h want 0",
                     {o_busy, o_done, o_err, o_init, o_fill, o_mem_we, o_fifo_rd},
                     o_mem_addr, o_mem_wdata);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b want 0", o_busy);
        end
    endtask

    task automatic test_basic;
        int  init_n = 0, init_cyc = -1, done_cyc = -1;
        logic fill_at_done = 1'b1;
        wr_t e;
        for (int i = 0; i < 4; i++) push_word(32'hA0 + i, ADDR_W'(16 + i), 1'b1);
        start_load(LEN_W'(4), ADDR_W'(16));
        for (int cyc = 1; cyc <= 18; cyc++) begin
            if (o_init) begin init_n++; init_cyc = cyc; end
            if (o_done) begin done_cyc = cyc; fill_at_done = o_fill; end
            if (o_mem_we && i_mem_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({o_mem_addr, o_mem_wdata} !== e) begin
                    n_err++;
                    $display("FAIL basic_write: got %h<-%h want %h<-%h",
                             o_mem_addr, o_mem_wdata, e.addr, e.data);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (init_n != 1 || init_cyc != 1) begin
            n_err++;
            $display("FAIL basic_init: count=%0d cycle=%0d want 1/1", init_n, init_cyc);
        end
        n_cmp++;
        if (done_cyc != 14 || fill_at_done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done: cycle=%0d fill=%b want 14/0", done_cyc, fill_at_done);
        end
        n_cmp++;
        if (exp_q.size() != 0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_end: pending=%0d busy=%b want 0/0", exp_q.size(), o_busy);
        end
    endtask

    task automatic test_backpressure;
        int  stall = 0, done_cyc = -1, pops0;
        logic [ADDR_W-1:0] a0;
        logic [31:0] d0;
        wr_t e;
        pops0 = pop_cnt;
        push_word(32'hB0, ADDR_W'(32), 1'b1);
        push_word(32'hB1, ADDR_W'(33), 1'b1);
        start_load(LEN_W'(2), ADDR_W'(32));
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (o_mem_we && stall < 5) begin
                i_mem_ready = 1'b0;
                if (stall == 0) begin
                    a0 = o_mem_addr;
                    d0 = o_mem_wdata;
                end else begin
                    n_cmp++;
                    if (o_mem_addr !== a0 || o_mem_wdata !== d0 || o_fifo_rd !== 1'b0) begin
                        n_err++;
                        $display("FAIL bp_stable: got %h<-%h rd=%b want %h<-%h rd=0",
                                 o_mem_addr, o_mem_wdata, o_fifo_rd, a0, d0);
                    end
                end
                stall++;
            end else begin
                i_mem_ready = 1'b1;
            end
            if (o_done) done_cyc = cyc;
            if (o_mem_we && i_mem_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({o_mem_addr, o_mem_wdata} !== e) begin
                    n_err++;
                    $display("FAIL bp_write: got %h<-%h want %h<-%h",
                             o_mem_addr, o_mem_wdata, e.addr, e.data);
                end
            end
            @(negedge clk);
        end
        i_mem_ready = 1'b1;
        n_cmp++;
        if (done_cyc != 13) begin
            n_err++;
            $display("FAIL bp_done: cycle=%0d want 13", done_cyc);
        end
        n_cmp++;
        if (pop_cnt - pops0 != 2 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_pops: pops=%0d pending=%0d want 2/0", pop_cnt - pops0, exp_q.size());
        end
    endtask

    task automatic test_timeout;
        bit done_seen = 0;
        int pops0;
        pops0 = pop_cnt;
        start_load(LEN_W'(2), ADDR_W'(0));
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (o_done) done_seen = 1;
            if (cyc == 9) begin
                n_cmp++;
                if (o_busy !== 1'b1 || o_err !== 1'b0 || o_fill !== 1'b1) begin
                    n_err++;
                    $display("FAIL tmo_early: busy=%b err=%b fill=%b want 1/0/1",
                             o_busy, o_err, o_fill);
                end
            end
            if (cyc == 10) begin
                n_cmp++;
                if (o_err !== 1'b1 || o_fill !== 1'b0 || o_busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL tmo_err: err=%b fill=%b busy=%b want 1/0/0",
                             o_err, o_fill, o_busy);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done_seen || pop_cnt != pops0 || o_err !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_end: done=%0d pops=%0d err=%b want 0/0/1",
                     done_seen, pop_cnt - pops0, o_err);
        end
    endtask

    task automatic test_wrap;
        int done_cyc = -1;
        wr_t e;
        push_word(32'hC0, ADDR_W'(16382), 1'b1);
        push_word(32'hC1, ADDR_W'(16383), 1'b1);
        push_word(32'hC2, ADDR_W'(0), 1'b1);
        start_load(LEN_W'(3), ADDR_W'(16382));
        n_cmp++;
        if (o_err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear: err=%b want 0", o_err);
        end
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (o_done) done_cyc = cyc;
            if (o_mem_we && i_mem_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({o_mem_addr, o_mem_wdata} !== e) begin
                    n_err++;
                    $display("FAIL wrap_write: got %h<-%h want %h<-%h",
                             o_mem_addr, o_mem_wdata, e.addr, e.data);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done_cyc != 11 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL wrap_done: cycle=%0d pending=%0d want 11/0", done_cyc, exp_q.size());
        end
    endtask

    task automatic test_zero_len;
        int  done_cyc = -1;
        bit  init_seen = 0, rd_seen = 0;
        logic busy2 = 1'b1;
        start_load(LEN_W'(0), ADDR_W'(5));
        for (int cyc = 1; cyc <= 5; cyc++) begin
            if (o_done && done_cyc < 0) done_cyc = cyc;
            if (o_init) init_seen = 1;
            if (o_fifo_rd || o_mem_we) rd_seen = 1;
            if (cyc == 2) busy2 = o_busy;
            @(negedge clk);
        end
        n_cmp++;
        if (done_cyc != 1 || init_seen || rd_seen || busy2 !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len: done_cyc=%0d init=%0d rd=%0d busy2=%b want 1/0/0/0",
                     done_cyc, init_seen, rd_seen, busy2);
        end
    endtask

    task automatic test_abort;
        int abort_cyc = -1;
        bit done_seen = 0;
        i_mem_ready = 1'b0;
        push_word(32'hD0, ADDR_W'(64), 1'b0);
        start_load(LEN_W'(1), ADDR_W'(64));
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (o_done) done_seen = 1;
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                i_abort = 1'b0;
                n_cmp++;
                if (o_mem_we !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL abort_wr: we=%b busy=%b err=%b want 0/0/0",
                             o_mem_we, o_busy, o_err);
                end
            end else if (o_mem_we && abort_cyc < 0) begin
                i_abort   = 1'b1;
                abort_cyc = cyc;
            end
            @(negedge clk);
        end
        i_mem_ready = 1'b1;
        n_cmp++;
        if (abort_cyc != 4 || done_seen) begin
            n_err++;
            $display("FAIL abort_seq: abort_cyc=%0d done=%0d want 4/0", abort_cyc, done_seen);
        end
    endtask

    task automatic test_collisions;
        int  done_cyc = -1;
        bit  busy_late = 0;
        wr_t e;
        @(negedge clk);
        i_start = 1'b1;
        i_abort = 1'b1;
        i_len   = LEN_W'(3);
        @(negedge clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b0 || o_init !== 1'b0) begin
            n_err++;
            $display("FAIL start_abort: busy=%b init=%b want 0/0", o_busy, o_init);
        end
        push_word(32'hE0, ADDR_W'(80), 1'b1);
        start_load(LEN_W'(1), ADDR_W'(80));
        for (int cyc = 1; cyc <= 9; cyc++) begin
            if (cyc == 2) begin
                i_start = 1'b1;
                i_len   = LEN_W'(5);
                i_base  = ADDR_W'(256);
            end
            if (cyc == 3) i_start = 1'b0;
            if (o_done) done_cyc = cyc;
            if (cyc >= 6 && o_busy) busy_late = 1;
            if (o_mem_we && i_mem_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({o_mem_addr, o_mem_wdata} !== e) begin
                    n_err++;
                    $display("FAIL busy_start_write: got %h<-%h want %h<-%h",
                             o_mem_addr, o_mem_wdata, e.addr, e.data);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done_cyc != 5 || busy_late || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL busy_start: done_cyc=%0d busy_late=%0d pending=%0d want 5/0/0",
                     done_cyc, busy_late, exp_q.size());
        end
    endtask

    task automatic test_async_reset;
        bit activity = 0;
        push_word(32'hF0, ADDR_W'(96), 1'b0);
        start_load(LEN_W'(1), ADDR_W'(96));
        @(negedge clk);
        @(negedge clk);
        // Cycle 3: CAP. Reset lands between edges.
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({o_busy, o_done, o_err, o_init, o_fill, o_mem_we, o_fifo_rd} !== 7'b0 ||
            o_mem_addr !== '0 || o_mem_wdata !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: flags=%b addr=%h data=%h want 0",
                     {o_busy, o_done, o_err, o_init, o_fill, o_mem_we, o_fifo_rd},
                     o_mem_addr, o_mem_wdata);
        end
        #1 reset = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (o_busy || o_init || o_mem_we || o_fifo_rd) activity = 1;
        end
        n_cmp++;
        if (activity) begin
            n_err++;
            $display("FAIL post_reset: activity=%0d want 0", activity);
        end
    endtask

    initial begin
        reset       = 1'b1;
        i_start     = 1'b0;
        i_abort     = 1'b0;
        i_len       = '0;
        i_base      = '0;
        i_mem_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_wrap();
        test_zero_len();
        test_abort();
        test_collisions();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

endmodule
